gpipe_raster_rx: RTL and testbench

GPIPE_RASTER_RX -- requirements
Module: gpipe_raster_rx

---
 rtl/gpipe_pkg.sv | 50 +++++
 rtl/raster_edge_eval.sv | 37 +++
 rtl/gpipe_raster_rx.sv | 257 +++++++++++++++++++++++++
 tb/tb_gpipe_raster_rx.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpipe_pkg.sv
// rtl/gpipe_pkg.sv - shared gpipe types: command encoding, coordinate widths, fragment record
// Purpose: definitions shared by the command sender and the raster receiver.
// Ports: none (package).
package gpipe_pkg;

  // Vertex coordinates are signed 16-bit. Differences need one extra bit,
  // products of two differences double that, and the difference of two
  // products needs one more.
  localparam int COORD_W = 16;
  localparam int DIFF_W  = COORD_W + 1;
  localparam int PROD_W  = 2 * DIFF_W;
  localparam int EDGE_W  = PROD_W + 1;

  // Codes 5..7 have no enumerator on purpose: the receiver accepts and drops them.
  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_SET_V0 = 3'd1,
    CMD_SET_V1 = 3'd2,
    CMD_SET_V2 = 3'd3,
    CMD_DRAW   = 3'd4
  } gpipe_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SCAN  = 2'd2,
    ST_EMIT  = 2'd3
  } raster_state_e;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef logic signed [EDGE_W-1:0]  edge_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } gpipe_frag_t;

  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

endpackage

// File: rtl/raster_edge_eval.sv
// rtl/raster_edge_eval.sv - combinational evaluation of one triangle edge function
// Purpose: E = (xb-xa)*(py-ya) - (yb-ya)*(px-xa) for edge a->b and point p.
// Ports:
//   i_xa, i_ya  in  COORD_W  edge start vertex (signed)
//   i_xb, i_yb  in  COORD_W  edge end vertex (signed)
//   i_px, i_py  in  COORD_W  evaluation point (signed)
//   o_e         out EDGE_W   signed edge value
module raster_edge_eval
  import gpipe_pkg::*;
(
  input  logic signed [COORD_W-1:0] i_xa,
  input  logic signed [COORD_W-1:0] i_ya,
  input  logic signed [COORD_W-1:0] i_xb,
  input  logic signed [COORD_W-1:0] i_yb,
  input  logic signed [COORD_W-1:0] i_px,
  input  logic signed [COORD_W-1:0] i_py,
  output logic signed [EDGE_W-1:0]  o_e
);

  logic signed [DIFF_W-1:0] w_dx_ab;
  logic signed [DIFF_W-1:0] w_dy_ab;
  logic signed [DIFF_W-1:0] w_dx_ap;
  logic signed [DIFF_W-1:0] w_dy_ap;
  logic signed [PROD_W-1:0] w_p0;
  logic signed [PROD_W-1:0] w_p1;

  assign w_dx_ab = DIFF_W'(i_xb) - DIFF_W'(i_xa);
  assign w_dy_ab = DIFF_W'(i_yb) - DIFF_W'(i_ya);
  assign w_dx_ap = DIFF_W'(i_px) - DIFF_W'(i_xa);
  assign w_dy_ap = DIFF_W'(i_py) - DIFF_W'(i_ya);

  assign w_p0 = PROD_W'(w_dx_ab) * PROD_W'(w_dy_ap);
  assign w_p1 = PROD_W'(w_dy_ab) * PROD_W'(w_dx_ap);

  assign o_e = EDGE_W'(w_p0) - EDGE_W'(w_p1);

endmodule

// File: rtl/gpipe_raster_rx.sv
// rtl/gpipe_raster_rx.sv - triangle rasteriser: vertex commands in, raster-order fragments out
// Purpose: latches three vertices from SET_Vn commands; a DRAW computes the
//   clamped bounding box and signed area, then walks the box in raster order,
//   emitting one fragment per covered pixel (edges inclusive).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_type              gpipe_cmd_e encoding
//   cmd_data_x/_y         vertex coordinates, low 16 bits signed
//   frag_valid/frag_ready fragment handshake
//   frag_x/frag_y         fragment coordinates, unsigned
//   busy                  any state other than IDLE
//   draw_done             one-cycle pulse when a DRAW finishes
module gpipe_raster_rx
  import gpipe_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_type,
  input  logic [31:0] cmd_data_x,
  input  logic [31:0] cmd_data_y,
  output logic        frag_valid,
  input  logic        frag_ready,
  output logic [15:0] frag_x,
  output logic [15:0] frag_y,
  output logic        busy,
  output logic        draw_done
);

  localparam logic signed [DIFF_W-1:0] X_LIM = DIFF_W'(SCREEN_W - 1);
  localparam logic signed [DIFF_W-1:0] Y_LIM = DIFF_W'(SCREEN_H - 1);

  raster_state_e r_state;
  raster_state_e w_state_nxt;

  logic signed [COORD_W-1:0] r_v0_x, r_v0_y;
  logic signed [COORD_W-1:0] r_v1_x, r_v1_y;
  logic signed [COORD_W-1:0] r_v2_x, r_v2_y;

  logic [COORD_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic [COORD_W-1:0] r_ptr_x, r_ptr_y;
  logic               r_area_neg;
  gpipe_frag_t        r_frag;

  logic w_cmd_fire;
  logic [31:0] w_unused_hi;

  // Upper halves of the command data words carry nothing.
  assign w_unused_hi = {cmd_data_x[31:16], cmd_data_y[31:16]};
  assign w_cmd_fire  = cmd_valid && (r_state == ST_IDLE);

  // ---------------------------------------------------------------------------
  // Bounding box. Min is clamped only from below and max only from above, so a
  // triangle lying entirely off one side yields min > max (empty box).
  // ---------------------------------------------------------------------------
  logic signed [COORD_W-1:0] w_bx_min, w_bx_max, w_by_min, w_by_max;
  logic signed [DIFF_W-1:0]  w_xmin_c, w_xmax_c, w_ymin_c, w_ymax_c;
  logic                      w_box_empty;

  assign w_bx_min = min3(r_v0_x, r_v1_x, r_v2_x);
  assign w_bx_max = max3(r_v0_x, r_v1_x, r_v2_x);
  assign w_by_min = min3(r_v0_y, r_v1_y, r_v2_y);
  assign w_by_max = max3(r_v0_y, r_v1_y, r_v2_y);

  always_comb begin
    w_xmin_c = DIFF_W'(w_bx_min);
    w_xmax_c = DIFF_W'(w_bx_max);
    w_ymin_c = DIFF_W'(w_by_min);
    w_ymax_c = DIFF_W'(w_by_max);
    if (w_xmin_c < 0)     w_xmin_c = '0;
    if (w_ymin_c < 0)     w_ymin_c = '0;
    if (w_xmax_c > X_LIM) w_xmax_c = X_LIM;
    if (w_ymax_c > Y_LIM) w_ymax_c = Y_LIM;
  end

  assign w_box_empty = (w_xmin_c > w_xmax_c) || (w_ymin_c > w_ymax_c);

  // ---------------------------------------------------------------------------
  // Edge functions. During SETUP the evaluation point is V2, which turns E01
  // into the signed area A, so no separate area multiplier is needed.
  // ---------------------------------------------------------------------------
  logic signed [COORD_W-1:0] w_px, w_py;
  logic signed [EDGE_W-1:0]  w_e01, w_e12, w_e20;
  logic                      w_area_zero;
  logic                      w_all_ge, w_all_le, w_inside;

  assign w_px = (r_state == ST_SETUP) ? r_v2_x : $signed(r_ptr_x);
  assign w_py = (r_state == ST_SETUP) ? r_v2_y : $signed(r_ptr_y);

  raster_edge_eval u_edge01 (
    .i_xa(r_v0_x), .i_ya(r_v0_y), .i_xb(r_v1_x), .i_yb(r_v1_y),
    .i_px(w_px),   .i_py(w_py),   .o_e(w_e01)
  );

  raster_edge_eval u_edge12 (
    .i_xa(r_v1_x), .i_ya(r_v1_y), .i_xb(r_v2_x), .i_yb(r_v2_y),
    .i_px(w_px),   .i_py(w_py),   .o_e(w_e12)
  );

  raster_edge_eval u_edge20 (
    .i_xa(r_v2_x), .i_ya(r_v2_y), .i_xb(r_v0_x), .i_yb(r_v0_y),
    .i_px(w_px),   .i_py(w_py),   .o_e(w_e20)
  );

  assign w_area_zero = (w_e01 == '0);

  assign w_all_ge = !w_e01[EDGE_W-1] && !w_e12[EDGE_W-1] && !w_e20[EDGE_W-1];
  assign w_all_le = (w_e01 <= 0) && (w_e12 <= 0) && (w_e20 <= 0);
  // Winding follows the sign of A so both vertex orders cover the same pixels.
  assign w_inside = r_area_neg ? w_all_le : w_all_ge;

  // ---------------------------------------------------------------------------
  // Raster-order pointer stepping.
  // ---------------------------------------------------------------------------
  logic               w_at_row_end;
  logic               w_at_end;
  logic [COORD_W-1:0] w_next_x, w_next_y;

  assign w_at_row_end = (r_ptr_x == r_xmax);
  assign w_at_end     = w_at_row_end && (r_ptr_y == r_ymax);
  assign w_next_x     = w_at_row_end ? r_xmin : COORD_W'(r_ptr_x + 16'd1);
  assign w_next_y     = w_at_row_end ? COORD_W'(r_ptr_y + 16'd1) : r_ptr_y;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_fire && (cmd_type == CMD_DRAW)) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        if (w_area_zero || w_box_empty) w_state_nxt = ST_IDLE;
        else                            w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_inside)      w_state_nxt = ST_EMIT;
        else if (w_at_end) w_state_nxt = ST_IDLE;
      end
      ST_EMIT: begin
        if (frag_ready) w_state_nxt = w_at_end ? ST_IDLE : ST_SCAN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs. draw_done is combinational so it coincides with the cycle
  // that finishes the draw (degenerate SETUP, last reject or last handshake).
  always_comb begin
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    frag_valid = 1'b0;
    draw_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_SETUP: draw_done = w_area_zero || w_box_empty;
      ST_SCAN:  draw_done = !w_inside && w_at_end;
      ST_EMIT: begin
        frag_valid = 1'b1;
        draw_done  = frag_ready && w_at_end;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v0_x     <= '0;
      r_v0_y     <= '0;
      r_v1_x     <= '0;
      r_v1_y     <= '0;
      r_v2_x     <= '0;
      r_v2_y     <= '0;
      r_xmin     <= '0;
      r_xmax     <= '0;
      r_ymin     <= '0;
      r_ymax     <= '0;
      r_ptr_x    <= '0;
      r_ptr_y    <= '0;
      r_area_neg <= 1'b0;
      r_frag     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            case (cmd_type)
              CMD_SET_V0: begin
                r_v0_x <= $signed(cmd_data_x[COORD_W-1:0]);
                r_v0_y <= $signed(cmd_data_y[COORD_W-1:0]);
              end
              CMD_SET_V1: begin
                r_v1_x <= $signed(cmd_data_x[COORD_W-1:0]);
                r_v1_y <= $signed(cmd_data_y[COORD_W-1:0]);
              end
              CMD_SET_V2: begin
                r_v2_x <= $signed(cmd_data_x[COORD_W-1:0]);
                r_v2_y <= $signed(cmd_data_y[COORD_W-1:0]);
              end
              default: ;
            endcase
          end
        end
        ST_SETUP: begin
          // Truncation is safe: when the draw proceeds the box is inside the viewport.
          r_xmin     <= w_xmin_c[COORD_W-1:0];
          r_xmax     <= w_xmax_c[COORD_W-1:0];
          r_ymin     <= w_ymin_c[COORD_W-1:0];
          r_ymax     <= w_ymax_c[COORD_W-1:0];
          r_ptr_x    <= w_xmin_c[COORD_W-1:0];
          r_ptr_y    <= w_ymin_c[COORD_W-1:0];
          r_area_neg <= w_e01[EDGE_W-1];
        end
        ST_SCAN: begin
          if (w_inside) begin
            r_frag.x <= r_ptr_x;
            r_frag.y <= r_ptr_y;
          end else begin
            r_ptr_x <= w_next_x;
            r_ptr_y <= w_next_y;
          end
        end
        ST_EMIT: begin
          if (frag_ready) begin
            r_ptr_x <= w_next_x;
            r_ptr_y <= w_next_y;
          end
        end
        default: ;
      endcase
    end
  end

  assign frag_x = r_frag.x;
  assign frag_y = r_frag.y;

endmodule

// File: tb/tb_gpipe_raster_rx.sv
// tb/tb_gpipe_raster_rx.sv - self-checking bench for gpipe_raster_rx
module tb_gpipe_raster_rx;
  import gpipe_pkg::*;

  localparam int W = 640;
  localparam int H = 480;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_type = 3'd0;
  logic [31:0] cmd_data_x = '0;
  logic [31:0] cmd_data_y = '0;
  logic        frag_valid;
  logic        frag_ready = 1'b1;
  logic [15:0] frag_x, frag_y;
  logic        busy;
  logic        draw_done;

  gpipe_raster_rx #(.SCREEN_W(W), .SCREEN_H(H)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_data_x(cmd_data_x), .cmd_data_y(cmd_data_y),
    .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_x(frag_x), .frag_y(frag_y),
    .busy(busy), .draw_done(draw_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int first_valid_cyc = -1;
  int last_accept = 0;
  gpipe_frag_t exp_q[$];

  typedef struct {
    int x0, y0, x1, y1, x2, y2;
    int exp_frags;   // -1: take the count from the reference model
    int lat;         // 1: first-fragment latency, 2: degenerate timing, 3: 9 rejects
  } vec_t;

  vec_t vecs[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard side: compare every handshaked fragment against the queue.
  always @(negedge clk) begin
    if (frag_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (frag_valid && frag_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_fragment", 1, 0);
      end else begin
        gpipe_frag_t e;
        e = exp_q.pop_front();
        chk("frag_x", frag_x, e.x);
        chk("frag_y", frag_y, e.y);
      end
    end
    if (draw_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic bit model_inside(input int x0, input int y0, input int x1, input int y1,
                                      input int x2, input int y2, input int px, input int py);
    longint a, e0, e1, e2;
    a  = longint'(x1 - x0) * (y2 - y0) - longint'(y1 - y0) * (x2 - x0);
    e0 = longint'(x1 - x0) * (py - y0) - longint'(y1 - y0) * (px - x0);
    e1 = longint'(x2 - x1) * (py - y1) - longint'(y2 - y1) * (px - x1);
    e2 = longint'(x0 - x2) * (py - y2) - longint'(y0 - y2) * (px - x2);
    if (a == 0) return 1'b0;
    if (a > 0) return (e0 >= 0) && (e1 >= 0) && (e2 >= 0);
    return (e0 <= 0) && (e1 <= 0) && (e2 <= 0);
  endfunction

  task automatic fill_model(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2, output int cnt);
    gpipe_frag_t f;
    int xl, xh, yl, yh;
    cnt = 0;
    xl = x0; if (x1 < xl) xl = x1; if (x2 < xl) xl = x2;
    xh = x0; if (x1 > xh) xh = x1; if (x2 > xh) xh = x2;
    yl = y0; if (y1 < yl) yl = y1; if (y2 < yl) yl = y2;
    yh = y0; if (y1 > yh) yh = y1; if (y2 > yh) yh = y2;
    if (xl < 0) xl = 0;
    if (yl < 0) yl = 0;
    if (xh > W - 1) xh = W - 1;
    if (yh > H - 1) yh = H - 1;
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        if (model_inside(x0, y0, x1, y1, x2, y2, x, y)) begin
          f.x = 16'(x);
          f.y = 16'(y);
          exp_q.push_back(f);
          cnt++;
        end
      end
    end
  endtask

  task automatic send_cmd(input logic [2:0] t, input int x, input int y);
    int n;
    n = 0;
    @(posedge clk); #1;
    cmd_valid  = 1'b1;
    cmd_type   = t;
    cmd_data_x = {16'hA5C3, x[15:0]};
    cmd_data_y = {16'h5A3C, y[15:0]};
    @(negedge clk);
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
    @(posedge clk); #1;
    last_accept = cyc;
    cmd_valid = 1'b0;
    cmd_type  = 3'd0;
  endtask

  task automatic wait_done(input int prev);
    int n;
    n = 0;
    while (done_cnt == prev && n < 3000) begin
      @(negedge clk); #1;
      n++;
    end
    if (done_cnt == prev) chk("draw_done_timeout", 0, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("draw_done_pulses", done_cnt - prev, 1);
  endtask

  task automatic wait_hs(input int target);
    int n;
    n = 0;
    while (hs_cnt < target && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    if (hs_cnt < target) chk("handshake_timeout", hs_cnt, target);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frag_valid && n < 100);
    if (!frag_valid) chk("frag_valid_timeout", 0, 1);
  endtask

  task automatic set_tri(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2);
    send_cmd(CMD_SET_V0, x0, y0);
    send_cmd(CMD_SET_V1, x1, y1);
    send_cmd(CMD_SET_V2, x2, y2);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int mcnt, hs0, d0, exp_n;
    set_tri(v.x0, v.y0, v.x1, v.y1, v.x2, v.y2);
    send_cmd(3'd6, 77, 77);   // reserved code, must be dropped
    fill_model(v.x0, v.y0, v.x1, v.y1, v.x2, v.y2, mcnt);
    exp_n = (v.exp_frags < 0) ? mcnt : v.exp_frags;
    hs0 = hs_cnt;
    d0 = done_cnt;
    first_valid_cyc = -1;
    send_cmd(CMD_DRAW, 0, 0);
    if (v.lat == 2) begin
      @(negedge clk);
      chk($sformatf("v%0d_done_at_n1", idx), draw_done, 1);
      @(negedge clk);
      chk($sformatf("v%0d_ready_at_n2", idx), cmd_ready, 1);
    end
    wait_done(d0);
    if (v.lat == 1) chk($sformatf("v%0d_first_valid_latency", idx), first_valid_cyc - last_accept, 2);
    if (v.lat == 3) chk($sformatf("v%0d_reject_cycles", idx), done_cyc - last_accept, 9);
    chk($sformatf("v%0d_frag_count", idx), hs_cnt - hs0, exp_n);
    chk($sformatf("v%0d_queue_left", idx), exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got 0 expected 1");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, d0, mcnt;

    vecs[0] = '{0, 0, 4, 0, 0, 4, 15, 1};
    vecs[1] = '{0, 0, 0, 4, 4, 0, 15, 1};
    vecs[2] = '{0, 0, 2, 2, 4, 4, 0, 2};
    vecs[3] = '{-3, -3, 2, -3, -3, 2, 0, 3};
    vecs[4] = '{10, 10, 12, 10, 10, 12, 6, 1};
    vecs[5] = '{636, 0, 645, 0, 636, 9, 34, 0};
    vecs[6] = '{-5, -5, -1, -5, -5, -1, 0, 2};
    vecs[7] = '{1, 0, 7, 3, 2, 6, -1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_frag_valid", frag_valid, 0);
    chk("rst_frag_x", frag_x, 0);
    chk("rst_frag_y", frag_y, 0);
    chk("rst_draw_done", draw_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-pressure on the 3rd fragment; commands offered while busy are ignored.
    frag_ready = 1'b1;
    set_tri(0, 0, 4, 0, 0, 4);
    fill_model(0, 0, 4, 0, 0, 4, mcnt);
    hs0 = hs_cnt;
    d0 = done_cnt;
    send_cmd(CMD_DRAW, 0, 0);
    wait_hs(hs0 + 2);
    @(posedge clk); #1;
    frag_ready = 1'b0;
    cmd_valid  = 1'b1;
    cmd_type   = CMD_SET_V0;
    cmd_data_x = 32'd100;
    cmd_data_y = 32'd100;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_frag_valid", frag_valid, 1);
      chk("stall_frag_x", frag_x, 2);
      chk("stall_frag_y", frag_y, 0);
      chk("stall_cmd_ready", cmd_ready, 0);
      chk("stall_busy", busy, 1);
      chk("stall_no_handshake", hs_cnt - hs0, 2);
    end
    @(posedge clk); #1;
    frag_ready = 1'b1;
    cmd_valid  = 1'b0;
    cmd_type   = 3'd0;
    wait_done(d0);
    chk("stall_frag_count", hs_cnt - hs0, 15);
    chk("stall_queue_left", exp_q.size(), 0);
    exp_q.delete();

    // Vertices persist: redraw without new SET commands.
    fill_model(0, 0, 4, 0, 0, 4, mcnt);
    hs0 = hs_cnt;
    d0 = done_cnt;
    send_cmd(CMD_DRAW, 0, 0);
    wait_done(d0);
    chk("persist_frag_count", hs_cnt - hs0, 15);
    chk("persist_queue_left", exp_q.size(), 0);
    exp_q.delete();

    // Reset during the 5th EMIT abandons the draw.
    fill_model(0, 0, 4, 0, 0, 4, mcnt);
    hs0 = hs_cnt;
    d0 = done_cnt;
    send_cmd(CMD_DRAW, 0, 0);
    wait_hs(hs0 + 4);
    @(posedge clk); #1;
    frag_ready = 1'b0;
    wait_valid();
    chk("emit5_frag_x", frag_x, 4);
    chk("emit5_frag_y", frag_y, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_frag_valid", frag_valid, 0);
    chk("midrst_frag_x", frag_x, 0);
    chk("midrst_frag_y", frag_y, 0);
    chk("midrst_draw_done", draw_done, 0);
    chk("midrst_busy", busy, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1;
    chk("midrst_no_done", done_cnt - d0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    frag_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    hs0 = hs_cnt;
    d0 = done_cnt;
    send_cmd(CMD_DRAW, 0, 0);
    @(negedge clk);
    chk("post_rst_done_n1", draw_done, 1);
    wait_done(d0);
    chk("post_rst_frag_count", hs_cnt - hs0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
